// File: rtl/ctrl_deslocamento_pkg.sv
// Shared types and helpers for the shift-job controller.
package ctrl_deslocamento_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Default widths; the job descriptor below is sized from these.
  localparam int DEF_BITS_DATA  = 4;
  localparam int DEF_BITS_SHIFT = 1;
  localparam int DEF_BITS_AMT   = 3;

  // Largest shift the shared shifter performs in one cycle.
  function automatic int step_max(input int bits_shift);
    return (1 << bits_shift) - 1;
  endfunction

  // One job as presented by a requester.
  typedef struct packed {
    logic signed [DEF_BITS_DATA-1:0] data;
    logic        [DEF_BITS_AMT-1:0]  amt;
  } req_t;

endpackage

// File: rtl/passo_deslocamento.sv
// Accumulator register for the shift datapath: load a new operand,
// arithmetic-shift right by one step, or hold.
module passo_deslocamento
  import ctrl_deslocamento_pkg::*;
#(
  parameter int BITS_DATA  = DEF_BITS_DATA,
  parameter int BITS_SHIFT = DEF_BITS_SHIFT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         shift_en,
  input  logic signed [BITS_DATA-1:0]  load_data,
  input  logic        [BITS_SHIFT-1:0] step,
  output logic signed [BITS_DATA-1:0]  acc
);

  logic signed [BITS_DATA-1:0] acc_reg;
  logic signed [BITS_DATA-1:0] acc_next;

  // Load has priority over shift; the two are never requested together.
  always_comb begin
    acc_next = acc_reg;
    if (load) begin
      acc_next = load_data;
    end else if (shift_en) begin
      acc_next = acc_reg >>> step;
    end
  end

  // Accumulator register, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/ctrl_deslocamento.sv
// Two-requester controller for the shared arithmetic right shifter.
// Round-robin arbitration, multi-cycle stepping, valid/ready response.
module ctrl_deslocamento
  import ctrl_deslocamento_pkg::*;
#(
  parameter int BITS_DATA  = DEF_BITS_DATA,
  parameter int BITS_SHIFT = DEF_BITS_SHIFT,
  parameter int BITS_AMT   = DEF_BITS_AMT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [1:0][BITS_DATA-1:0]    req_data,
  input  logic [1:0][BITS_AMT-1:0]     req_amt,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_id,
  output logic        [BITS_DATA-1:0]  rsp_data,
  output logic                         busy
);

  localparam int                  STEP_MAX     = step_max(BITS_SHIFT);
  localparam logic [BITS_AMT-1:0] STEP_MAX_AMT = BITS_AMT'(STEP_MAX);

  state_e                state_reg, state_next;
  logic                  prio_reg, prio_next;
  logic                  rsp_id_reg, rsp_id_next;
  logic [BITS_AMT-1:0]   remaining_reg, remaining_next;
  logic [BITS_DATA-1:0]  last_reg, last_next;

  logic                  any_valid;
  logic                  win;
  logic [BITS_AMT-1:0]   step_amt;
  logic [BITS_SHIFT-1:0] step;
  logic                  acc_load;
  logic                  acc_shift;
  logic signed [BITS_DATA-1:0] acc;

  // Arbiter: a lone requester wins; on a tie the prioritised one wins.
  always_comb begin
    any_valid = |req_valid;
    win       = 1'b0;
    if (req_valid == 2'b11) begin
      win = prio_reg;
    end else if (req_valid[1]) begin
      win = 1'b1;
    end
  end

  // Step size for this cycle: whatever is left, capped at the shifter's reach.
  always_comb begin
    step_amt = (remaining_reg > STEP_MAX_AMT) ? STEP_MAX_AMT : remaining_reg;
    step     = step_amt[BITS_SHIFT-1:0];
  end

  // Only the winner sees ready, and only while idle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == IDLE) && any_valid && (win == 1'(gi));
    end
  endgenerate

  // Next-state and control decode.
  always_comb begin
    state_next     = state_reg;
    prio_next      = prio_reg;
    rsp_id_next    = rsp_id_reg;
    remaining_next = remaining_reg;
    last_next      = last_reg;
    acc_load       = 1'b0;
    acc_shift      = 1'b0;
    rsp_valid      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          acc_load       = 1'b1;
          remaining_next = req_amt[win];
          rsp_id_next    = win;
          prio_next      = ~win;
          state_next     = (req_amt[win] == '0) ? RESP : SHIFT;
        end
      end
      SHIFT: begin
        acc_shift      = 1'b1;
        remaining_next = remaining_reg - step_amt;
        if (remaining_next == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          // Keep the delivered result visible after leaving RESP.
          last_next  = acc;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      prio_reg      <= 1'b0;
      rsp_id_reg    <= 1'b0;
      remaining_reg <= '0;
      last_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      prio_reg      <= prio_next;
      rsp_id_reg    <= rsp_id_next;
      remaining_reg <= remaining_next;
      last_reg      <= last_next;
    end
  end

  passo_deslocamento #(
    .BITS_DATA  (BITS_DATA),
    .BITS_SHIFT (BITS_SHIFT)
  ) u_passo (
    .clk       (clk),
    .reset     (reset),
    .load      (acc_load),
    .shift_en  (acc_shift),
    .load_data (req_data[win]),
    .step      (step),
    .acc       (acc)
  );

  assign rsp_id   = rsp_id_reg;
  assign rsp_data = (state_reg == RESP) ? acc : last_reg;
  assign busy     = (state_reg != IDLE);

endmodule
